jpeg_idct_pass_arbiter: RTL and testbench



---
 rtl/jpeg_idct_pass_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_jpeg_idct_pass_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_idct_pass_arbiter.sv
// Row/column pass arbiter in front of a shared 1-D IDCT core, with a one-deep registered output stage.
// Optional beat-index checking is enabled with `define JPEG_IDCT_ARB_CHECK_EN.
module jpeg_idct_pass_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        img_start_i,
    input  logic        row_valid_i,
    input  logic [31:0] row_data0_i,
    input  logic [31:0] row_data1_i,
    input  logic [31:0] row_data2_i,
    input  logic [31:0] row_data3_i,
    input  logic [2:0]  row_idx_i,
    output logic        row_ready_o,
    input  logic        col_valid_i,
    input  logic [31:0] col_data0_i,
    input  logic [31:0] col_data1_i,
    input  logic [31:0] col_data2_i,
    input  logic [31:0] col_data3_i,
    input  logic [2:0]  col_idx_i,
    output logic        col_ready_o,
    output logic        core_valid_o,
    output logic [31:0] core_data0_o,
    output logic [31:0] core_data1_o,
    output logic [31:0] core_data2_o,
    output logic [31:0] core_data3_o,
    output logic [2:0]  core_idx_o,
    output logic        core_pass_o,
    input  logic        core_ready_i,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_ROW = 2'd1,
        ST_GRANT_COL = 2'd2
    } state_t;

    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_beat_cnt;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_nxt;
    logic        r_core_valid;
    logic [31:0] r_core_data0;
    logic [31:0] r_core_data1;
    logic [31:0] r_core_data2;
    logic [31:0] r_core_data3;
    logic [2:0]  r_core_idx;
    logic        r_core_pass;
    logic        w_out_free;
    logic        w_row_ready;
    logic        w_col_ready;
    logic        w_accept;
    logic        w_flush;

    assign w_out_free = !r_core_valid || core_ready_i;
    assign w_flush    = rst_i || img_start_i;

    // Arbitration, grant handshakes and burst termination.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_row_ready  = 1'b0;
        w_col_ready  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (row_valid_i && col_valid_i) begin
                    if (r_starve_cnt == LP_STARVE_LIMIT) begin
                        w_state_nxt  = ST_GRANT_ROW;
                        w_starve_nxt = 4'd0;
                    end else begin
                        w_state_nxt = ST_GRANT_COL;
                        if (r_starve_cnt != 4'd15) begin
                            w_starve_nxt = r_starve_cnt + 4'd1;
                        end else begin
                            w_starve_nxt = r_starve_cnt;
                        end
                    end
                end else if (row_valid_i) begin
                    w_state_nxt  = ST_GRANT_ROW;
                    w_starve_nxt = 4'd0;
                end else if (col_valid_i) begin
                    w_state_nxt = ST_GRANT_COL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT_ROW: begin
                w_row_ready = w_out_free;
                w_accept    = row_valid_i && w_out_free;
                if (w_accept && (r_beat_cnt == 3'd7)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GRANT_ROW;
                end
            end
            ST_GRANT_COL: begin
                w_col_ready = w_out_free;
                w_accept    = col_valid_i && w_out_free;
                if (w_accept && (r_beat_cnt == 3'd7)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GRANT_COL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, beat counter and starvation counter; img_start flushes like reset.
    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= 3'd0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 3'd1;
            end else begin
                r_beat_cnt <= r_beat_cnt;
            end
        end
    end

    // Output stage toward the core: loads on accept, holds under backpressure.
    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_core_valid <= 1'b0;
            r_core_data0 <= 32'd0;
            r_core_data1 <= 32'd0;
            r_core_data2 <= 32'd0;
            r_core_data3 <= 32'd0;
            r_core_idx   <= 3'd0;
            r_core_pass  <= 1'b0;
        end else if (w_accept) begin
            r_core_valid <= 1'b1;
            r_core_pass  <= (r_state == ST_GRANT_COL);
            if (r_state == ST_GRANT_COL) begin
                r_core_data0 <= col_data0_i;
                r_core_data1 <= col_data1_i;
                r_core_data2 <= col_data2_i;
                r_core_data3 <= col_data3_i;
                r_core_idx   <= col_idx_i;
            end else begin
                r_core_data0 <= row_data0_i;
                r_core_data1 <= row_data1_i;
                r_core_data2 <= row_data2_i;
                r_core_data3 <= row_data3_i;
                r_core_idx   <= row_idx_i;
            end
        end else if (core_ready_i) begin
            r_core_valid <= 1'b0;
        end else begin
            r_core_valid <= r_core_valid;
        end
    end

`ifdef JPEG_IDCT_ARB_CHECK_EN
    logic       r_err;
    logic [2:0] w_in_idx;

    assign w_in_idx = (r_state == ST_GRANT_COL) ? col_idx_i : row_idx_i;

    // Sticky flag for a beat whose index disagrees with its position in the burst.
    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_in_idx != r_beat_cnt)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign row_ready_o  = w_row_ready;
    assign col_ready_o  = w_col_ready;
    assign core_valid_o = r_core_valid;
    assign core_data0_o = r_core_data0;
    assign core_data1_o = r_core_data1;
    assign core_data2_o = r_core_data2;
    assign core_data3_o = r_core_data3;
    assign core_idx_o   = r_core_idx;
    assign core_pass_o  = r_core_pass;
    assign busy_o       = (r_state != ST_IDLE) || r_core_valid;

endmodule

// File: tb/tb_jpeg_idct_pass_arbiter.sv
// Directed bench for jpeg_idct_pass_arbiter (STARVE_LIMIT = 2); honours JPEG_IDCT_ARB_CHECK_EN.
module tb_jpeg_idct_pass_arbiter;

`ifdef JPEG_IDCT_ARB_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        img_start_i = 1'b0;
    logic        row_valid_i = 1'b0;
    logic [31:0] row_data0_i = 32'd0, row_data1_i = 32'd0, row_data2_i = 32'd0, row_data3_i = 32'd0;
    logic [2:0]  row_idx_i = 3'd0;
    logic        row_ready_o;
    logic        col_valid_i = 1'b0;
    logic [31:0] col_data0_i = 32'd0, col_data1_i = 32'd0, col_data2_i = 32'd0, col_data3_i = 32'd0;
    logic [2:0]  col_idx_i = 3'd0;
    logic        col_ready_o;
    logic        core_valid_o;
    logic [31:0] core_data0_o, core_data1_o, core_data2_o, core_data3_o;
    logic [2:0]  core_idx_o;
    logic        core_pass_o;
    logic        core_ready_i = 1'b1;
    logic        busy_o;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    jpeg_idct_pass_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .img_start_i(img_start_i),
        .row_valid_i(row_valid_i), .row_data0_i(row_data0_i), .row_data1_i(row_data1_i),
        .row_data2_i(row_data2_i), .row_data3_i(row_data3_i), .row_idx_i(row_idx_i),
        .row_ready_o(row_ready_o),
        .col_valid_i(col_valid_i), .col_data0_i(col_data0_i), .col_data1_i(col_data1_i),
        .col_data2_i(col_data2_i), .col_data3_i(col_data3_i), .col_idx_i(col_idx_i),
        .col_ready_o(col_ready_o),
        .core_valid_o(core_valid_o), .core_data0_o(core_data0_o), .core_data1_o(core_data1_o),
        .core_data2_o(core_data2_o), .core_data3_o(core_data3_o), .core_idx_o(core_idx_o),
        .core_pass_o(core_pass_o), .core_ready_i(core_ready_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_beat(input logic is_col, input logic [2:0] idx, input logic [31:0] d0);
        if (is_col) begin
            col_idx_i = idx; col_data0_i = d0; col_data1_i = ~d0;
            col_data2_i = d0 ^ 32'h5555_5555; col_data3_i = {d0[15:0], d0[31:16]};
        end else begin
            row_idx_i = idx; row_data0_i = d0; row_data1_i = ~d0;
            row_data2_i = d0 ^ 32'h5555_5555; row_data3_i = {d0[15:0], d0[31:16]};
        end
    endtask

    // One accepted beat on the granted side, then the registered copy toward the core.
    task automatic beat(input logic is_col, input logic [2:0] idx, input logic [31:0] d0);
        set_beat(is_col, idx, d0);
        #1;
        chk("rdy_granted", is_col ? col_ready_o : row_ready_o, 32'd1);
        chk("rdy_other", is_col ? row_ready_o : col_ready_o, 32'd0);
        tick();
        chk("core_valid", core_valid_o, 32'd1);
        chk("core_idx", core_idx_o, idx);
        chk("core_d0", core_data0_o, d0);
        chk("core_d1", core_data1_o, ~d0);
        chk("core_d2", core_data2_o, d0 ^ 32'h5555_5555);
        chk("core_d3", core_data3_o, {d0[15:0], d0[31:16]});
        chk("core_pass", core_pass_o, is_col);
    endtask

    initial begin
        logic exp_col;
        logic [2:0] sidx;

        // Reset state
        repeat (3) tick();
        rst_i = 1'b0;
        #1;
        chk("rst_core_valid", core_valid_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_row_ready", row_ready_o, 32'd0);
        chk("rst_col_ready", col_ready_o, 32'd0);
        chk("rst_err", err_o, 32'd0);
        chk("rst_idx", core_idx_o, 32'd0);

        // Single row burst, data0 = idx
        row_valid_i = 1'b1;
        set_beat(1'b0, 3'd0, 32'd0);
        #1;
        chk("idle_row_ready", row_ready_o, 32'd0);
        tick();
        for (int k = 0; k < 8; k++) beat(1'b0, 3'(k), 32'(k));
        row_valid_i = 1'b0;
        #1;
        chk("end_row_ready", row_ready_o, 32'd0);
        tick();
        chk("drain_valid", core_valid_o, 32'd0);
        chk("drain_busy", busy_o, 32'd0);

        // Both valid continuously: col, col, row, col, col, row
        row_valid_i = 1'b1;
        col_valid_i = 1'b1;
        for (int b = 0; b < 6; b++) begin
            exp_col = (b % 3) != 2;
            #1;
            chk("arb_idle_row_rdy", row_ready_o, 32'd0);
            chk("arb_idle_col_rdy", col_ready_o, 32'd0);
            tick();
            for (int k = 0; k < 8; k++) begin
                set_beat(1'b0, 3'(k), 32'hA000_0000 + 32'(k) + 32'(b << 4));
                beat(1'b1 == exp_col, 3'(k), (exp_col ? 32'hC000_0000 : 32'hA000_0000) + 32'(k) + 32'(b << 4));
            end
        end
        row_valid_i = 1'b0;
        col_valid_i = 1'b0;
        tick();
        chk("starve_drain", core_valid_o, 32'd0);

        // Column burst stalled on beat 3
        col_valid_i = 1'b1;
        set_beat(1'b1, 3'd0, 32'h1000);
        tick();
        for (int k = 0; k < 4; k++) beat(1'b1, 3'(k), 32'h1000 + 32'(k));
        core_ready_i = 1'b0;
        set_beat(1'b1, 3'd4, 32'h1004);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_col_ready", col_ready_o, 32'd0);
            tick();
            chk("stall_valid", core_valid_o, 32'd1);
            chk("stall_idx", core_idx_o, 32'd3);
            chk("stall_d0", core_data0_o, 32'h1003);
        end
        core_ready_i = 1'b1;
        for (int k = 4; k < 8; k++) beat(1'b1, 3'(k), 32'h1000 + 32'(k));
        col_valid_i = 1'b0;
        tick();
        chk("stall_drain", core_valid_o, 32'd0);

        // Column drops valid mid-burst while row waits
        row_valid_i = 1'b1;
        col_valid_i = 1'b1;
        set_beat(1'b1, 3'd0, 32'h2000);
        tick();
        for (int k = 0; k < 5; k++) beat(1'b1, 3'(k), 32'h2000 + 32'(k));
        col_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("hold_row_ready", row_ready_o, 32'd0);
            tick();
            chk("hold_busy", busy_o, 32'd1);
            chk("hold_valid", core_valid_o, 32'd0);
        end
        col_valid_i = 1'b1;
        for (int k = 5; k < 8; k++) beat(1'b1, 3'(k), 32'h2000 + 32'(k));
        col_valid_i = 1'b0;
        set_beat(1'b0, 3'd0, 32'h3000);
        tick();

        // Row burst granted next, then img_start after beat 2
        for (int k = 0; k < 3; k++) beat(1'b0, 3'(k), 32'h3000 + 32'(k));
        set_beat(1'b0, 3'd3, 32'h3003);
        img_start_i = 1'b1;
        tick();
        img_start_i = 1'b0;
        row_valid_i = 1'b0;
        #1;
        chk("flush_valid", core_valid_o, 32'd0);
        chk("flush_row_ready", row_ready_o, 32'd0);
        chk("flush_col_ready", col_ready_o, 32'd0);
        chk("flush_busy", busy_o, 32'd0);
        row_valid_i = 1'b1;
        set_beat(1'b0, 3'd0, 32'h4000);
        tick();
        for (int k = 0; k < 8; k++) beat(1'b0, 3'(k), 32'h4000 + 32'(k));
        chk("post_flush_err", err_o, 32'd0);

        // Index sequence 0,1,3,4,...: err from the beat at position 2 onward when checking is built in
        set_beat(1'b0, 3'd0, 32'h5000);
        tick();
        for (int k = 0; k < 8; k++) begin
            sidx = (k < 2) ? 3'(k) : 3'(k + 1);
            beat(1'b0, sidx, 32'h5000 + 32'(k));
            chk("err_seq", err_o, (CHK_EN && k >= 2) ? 32'd1 : 32'd0);
        end
        row_valid_i = 1'b0;
        tick();
        chk("err_sticky", err_o, CHK_EN ? 32'd1 : 32'd0);
        img_start_i = 1'b1;
        tick();
        img_start_i = 1'b0;
        chk("err_cleared", err_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
